// File: rtl/alu_pkg.sv
// Package shared by the shift scheduler and its arbiter.
// Holds the opcode encodings, the scheduler FSM state type and small
// opcode-decoding helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    SH_SLL  = 3'b011,
    SH_SAR  = 3'b100,
    SH_ROTL = 3'b101,
    SH_ROTR = 3'b110
  } shift_op_e;

  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;
  localparam logic [2:0] OP_ROTR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Rotations only ever use the low four bits of the amount.
  function automatic logic op_is_rot(input logic [2:0] op);
    return (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SAR) || (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

endpackage

// File: rtl/alu_16bit_shift_sll_sar_rotationleft_rotationright.sv
// Shared 16-bit shift datapath (purely combinational).
// Ports:
//   en     - operation enable; result is 0 when low
//   op     - opcode (SLL/SAR/ROTL/ROTR, anything else yields 0)
//   a      - operand to shift
//   b      - shift amount (full 16 bits; rotations use b[3:0])
//   result - shifted value
module alu_16bit_shift_sll_sar_rotationleft_rotationright
  import alu_pkg::*;
(
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  logic [3:0] amt;
  logic [4:0] inv_amt;

  assign amt     = b[3:0];
  // For amt==0 this is 16, and a 16-bit value shifted by 16 is 0, so the
  // rotation degenerates cleanly to A.
  assign inv_amt = 5'd16 - {1'b0, amt};

  always_comb begin
    result = '0;
    if (en) begin
      case (op)
        OP_SLL:  result = (b >= 16'd16) ? 16'h0000 : (a << amt);
        OP_SAR:  result = (b >= 16'd16) ? {16{a[15]}} : 16'($signed(a) >>> amt);
        OP_ROTL: result = (a << amt) | (a >> inv_amt);
        OP_ROTR: result = (a >> amt) | (a << inv_amt);
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_rr_arb.sv
// Request arbiter for the shift scheduler.
// Round-robin (FIXED_PRIO=0) or fixed priority, lowest index wins (FIXED_PRIO=1).
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   req        - per-requester request vector
//   gnt_en     - grants may be issued this cycle
//   gnt        - one-hot grant (zero when gnt_en is low or no request)
//   gnt_idx    - index of the winner (valid when gnt_vld)
//   gnt_vld    - a grant is being issued this cycle
module alu_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIXED_PRIO = 0,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gnt_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_vld
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] base;
  logic            found;
  int              scan;

  assign base = (FIXED_PRIO != 0) ? '0 : ptr_q;

  // Scan base, base+1, ... wrapping at NUM_REQ; first requester found wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = (int'(base) + i) % NUM_REQ;
      if (!found && req[scan]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(scan);
      end
    end
  end

  assign gnt_vld = gnt_en && found;
  assign gnt     = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_shift_sched.sv
// Shares one 16-bit shift datapath among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (shift, register
// result) -> RESP (hold response until taken) -> IDLE.
// Optional feature macro: ALU_SHIFT_SCHED_ERR_EN (flag illegal opcodes on rsp_err).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - per-requester request handshake
//   req_a/req_b/req_op    - packed per-requester operand, amount, opcode
//   rsp_valid/rsp_ready   - response handshake
//   rsp_result/rsp_id     - shifted value and originating requester index
//   rsp_err               - illegal opcode flag (0 unless feature enabled)
//   busy                  - an operation is in flight
//   state_dbg             - current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Requesters hold valid and payload stable until ready; the scheduler
// holds rsp_* stable while rsp_valid is high and rsp_ready is low.
module alu_shift_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIXED_PRIO = 0,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err,
  output logic                  busy,
  output sched_state_e          state_dbg
);

  sched_state_e    state_q, state_d;
  logic            gnt_en, gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [15:0]     sel_a, sel_b;
  logic [2:0]      sel_op;
  logic [15:0]     a_q, b_q;
  logic [2:0]      op_q;
  logic [15:0]     shift_out;
  logic            err_d;

  // Grants only in IDLE and never while reset is asserted.
  assign gnt_en = rst_n && (state_q == IDLE);

  alu_rr_arb #(
    .NUM_REQ    (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .gnt_en  (gnt_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel_a  = req_a[16*int'(gnt_idx) +: 16];
    sel_b  = req_b[16*int'(gnt_idx) +: 16];
    sel_op = req_op[3*int'(gnt_idx) +: 3];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture; rotation amounts are reduced mod 16 before issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rsp_id <= '0;
    end else if (gnt_vld) begin
      a_q    <= sel_a;
      b_q    <= op_is_rot(sel_op) ? {12'b0, sel_b[3:0]} : sel_b;
      op_q   <= sel_op;
      rsp_id <= gnt_idx;
    end
  end

  alu_16bit_shift_sll_sar_rotationleft_rotationright u_shift (
    .en     (state_q == EXEC),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (shift_out)
  );

`ifdef ALU_SHIFT_SCHED_ERR_EN
  assign err_d = !op_is_legal(op_q);
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_result <= shift_out;
      rsp_err    <= err_d;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_shift_sched.sv
// Testbench for alu_shift_sched: directed vectors, expected responses queued
// by the drivers and checked by an independent response monitor.
module tb_alu_shift_sched;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        busy;
  sched_state_e state_dbg;

  // fixed-priority instance
  logic [3:0]  fp_req_valid;
  logic [3:0]  fp_req_ready;
  logic [63:0] fp_req_a;
  logic [63:0] fp_req_b;
  logic [11:0] fp_req_op;
  logic        fp_rsp_valid;
  logic        fp_rsp_ready;
  logic [15:0] fp_rsp_result;
  logic [1:0]  fp_rsp_id;
  logic        fp_rsp_err;
  logic        fp_busy;
  sched_state_e fp_state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q[$];   // {err, id, result}

  alu_shift_sched #(.NUM_REQ(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
  );

  alu_shift_sched #(.NUM_REQ(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_a(fp_req_a), .req_b(fp_req_b), .req_op(fp_req_op), .rsp_valid(fp_rsp_valid),
    .rsp_ready(fp_rsp_ready), .rsp_result(fp_rsp_result), .rsp_id(fp_rsp_id),
    .rsp_err(fp_rsp_err), .busy(fp_busy), .state_dbg(fp_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, written bit by bit
  function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    int amt;
    r = '0;
    amt = int'(b);
    case (op)
      3'b011: for (int i = 0; i < 16; i++) if (i >= amt) r[i] = a[i-amt];
      3'b100: for (int i = 0; i < 16; i++) r[i] = (i + amt < 16) ? a[i+amt] : a[15];
      3'b101: begin
        amt = amt % 16;
        for (int i = 0; i < 16; i++) r[(i+amt)%16] = a[i];
      end
      3'b110: begin
        amt = amt % 16;
        for (int i = 0; i < 16; i++) r[i] = a[(i+amt)%16];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic exp_err(input logic [2:0] op);
`ifdef ALU_SHIFT_SCHED_ERR_EN
    return !(op == 3'b011 || op == 3'b100 || op == 3'b101 || op == 3'b110);
`else
    return 1'b0;
`endif
  endfunction

  // driver: present one request, wait for its grant, queue the expected response
  task automatic issue(input int idx, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    logic accepted;
    logic [1:0] id;
    id = 2'(idx);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_op[3*idx +: 3]  = op;
    req_valid[idx]      = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      #1;
      if (req_ready[idx]) begin
        exp_q.push_back({exp_err(op), id, model(op, a, b)});
        accepted = 1'b1;
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) chk("accept_timeout", 32'(idx), 32'hFFFF_FFFF);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, busy}, 32'd0);
  endtask

  // all four requesters held valid; grants must follow start, start+1, ...
  task automatic arb_all(input int n, input int start);
    int got, exp_idx;
    got = 0;
    exp_idx = start;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'h0100 + 16'(i);
      req_b[16*i +: 16] = 16'd0;
      req_op[3*i +: 3]  = 3'b011;
    end
    req_valid = 4'hF;
    for (int c = 0; c < 100 && got < n; c++) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'h0) begin
        chk("rr_grant", {28'd0, req_ready}, 32'(4'(1) << exp_idx));
        exp_q.push_back({1'b0, 2'(exp_idx), model(3'b011, 16'h0100 + 16'(exp_idx), 16'd0)});
        exp_idx = (exp_idx + 1) % 4;
        got++;
        if (got == n) begin
          @(posedge clk);
          #1;
          req_valid = 4'h0;
        end
      end
    end
    chk("rr_grant_count", 32'(got), 32'(n));
    wait_idle();
  endtask

  // response monitor / scoreboard
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {16'd0, rsp_result}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_result", {16'd0, rsp_result}, {16'd0, e[15:0]});
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[17:16]});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[18]});
      end
    end
  end

  initial begin
    int grants;
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    fp_req_valid = 4'h0;
    fp_req_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    fp_req_b = '0;
    fp_req_op = {4{3'b011}};
    fp_rsp_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'h0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: SLL with latency check
    @(negedge clk);
    issue(0, 3'b011, 16'h00F1, 16'd4);
    chk("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_exec_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // 2: SAR / SLL boundaries
    issue(1, 3'b100, 16'h8000, 16'd3);   wait_idle();
    issue(1, 3'b100, 16'h8000, 16'd20);  wait_idle();
    issue(1, 3'b011, 16'h00F1, 16'd16);  wait_idle();
    issue(1, 3'b100, 16'h7FF0, 16'd4);   wait_idle();

    // 3: rotations
    issue(0, 3'b101, 16'h8001, 16'd1);   wait_idle();
    issue(3, 3'b110, 16'h8001, 16'd17);  wait_idle();
    issue(3, 3'b101, 16'h8001, 16'd16);  wait_idle();
    issue(2, 3'b110, 16'h1234, 16'd0);   wait_idle();

    // 6: illegal opcode
    issue(2, 3'b000, 16'h1234, 16'd5);   wait_idle();
    issue(1, 3'b111, 16'hFFFF, 16'd1);   wait_idle();

    // 5a: response stall, no new grant while waiting
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    issue(2, 3'b011, 16'h00FF, 16'd8);
    @(posedge clk);
    #1;
    req_a[63:48] = 16'h1234;
    req_b[63:48] = 16'd4;
    req_op[11:9] = 3'b110;
    req_valid[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_result", {16'd0, rsp_result}, 32'h0000_FF00);
      chk("stall_id", {30'd0, rsp_id}, 32'd2);
      chk("stall_req_ready", {28'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    issue(3, 3'b110, 16'h1234, 16'd4);
    wait_idle();

    // 5b: reset while in EXEC drops the operation and clears the pointer
    issue(2, 3'b011, 16'h0001, 16'd1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    req_valid = 4'hF;
    @(posedge clk);
    #1;
    chk("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_exec_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_exec_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'h0;
    rst_n = 1'b1;

    // 4: round-robin order after reset
    arb_all(5, 0);

    // 4: fixed priority always grants requester 0
    fp_req_valid = 4'hF;
    grants = 0;
    for (int c = 0; c < 60 && grants < 5; c++) begin
      @(negedge clk);
      if (fp_req_ready != 4'h0) begin
        chk("fp_grant", {28'd0, fp_req_ready}, 32'd1);
        grants++;
      end
      if (fp_rsp_valid) begin
        chk("fp_rsp_id", {30'd0, fp_rsp_id}, 32'd0);
        chk("fp_rsp_result", {16'd0, fp_rsp_result}, 32'h0000_0001);
      end
    end
    chk("fp_grant_count", 32'(grants), 32'd5);
    fp_req_valid = 4'h0;

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
